pzcorebus_axi_boundary_splitter: RTL
====================================

Name: pzcorebus_axi_boundary_splitter

Overview:
Request-path stage that sits directly upstream of the corebus-to-AXI simple bridge. It splits each corebus command into pieces that never cross a 4 KB boundary and never exceed MAX_BURST_LENGTH beats, so the bridge's one-to-one AW/AR mapping stays AXI-legal. For write commands it regenerates mdata_last at the end of every piece. It emits a per-piece final flag that a downstream response merger uses.

Parameters:
ADDRESS_WIDTH, 64, byte address width.
DATA_WIDTH, 128, data width in bits; power of two, 8..1024; BPW = DATA_WIDTH/8 bytes per word.
ID_WIDTH, 8, command ID width.
LENGTH_WIDTH, 10, length field width; value n means n words, 0 means 2**LENGTH_WIDTH words.
MAX_BURST_LENGTH, 256, maximum words per output piece; must be ≤ 4096/BPW.
PIECE_FIFO_DEPTH, 4, depth of the write-piece length FIFO.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_mcmd_valid  in  1  upstream command valid
o_scmd_accept  out  1  upstream command accept
i_mcmd_with_data  in  1  1 = write (has data), 0 = read
i_mid  in  ID_WIDTH  command ID
i_maddr  in  ADDRESS_WIDTH  start byte address, BPW-aligned
i_mlength  in  LENGTH_WIDTH  length in words
i_mdata_valid  in  1  upstream write-data valid
o_sdata_accept  out  1  upstream write-data accept
i_mdata  in  DATA_WIDTH  write data
i_mdata_byteen  in  DATA_WIDTH/8  byte enables
i_mdata_last  in  1  upstream last; ignored functionally, checked by SVA only
o_mcmd_valid  out  1  piece command valid
i_scmd_accept  in  1  downstream command accept
o_mcmd_with_data  out  1  copy of the captured type
o_mid  out  ID_WIDTH  copy of the captured ID
o_maddr  out  ADDRESS_WIDTH  piece address
o_mlength  out  LENGTH_WIDTH  piece length, same encoding as i_mlength
o_mcmd_final  out  1  1 on the last piece of the original command
o_mdata_valid  out  1  downstream data valid
i_sdata_accept  in  1  downstream data accept
o_mdata  out  DATA_WIDTH  passthrough of i_mdata
o_mdata_byteen  out  DATA_WIDTH/8  passthrough of i_mdata_byteen
o_mdata_last  out  1  regenerated per-piece last

Behaviour:
- Reset values: FSM=IDLE; o_mcmd_valid=0; o_mdata_valid=0; o_mdata_last=0; piece FIFO empty; beat counter=0. In IDLE o_scmd_accept=1.
- Command FSM, states IDLE and ISSUE.
  - IDLE: o_scmd_accept=1. On i_mcmd_valid, capture type, id, addr and remaining = decoded length (1..2**LENGTH_WIDTH, held in LENGTH_WIDTH+1 bits), then go to ISSUE. Latency: first piece is valid the cycle after capture.
  - ISSUE: o_scmd_accept=0.
- Piece computation is combinational from the registers:
  - room = (4096 - addr[11:0]) >> log2(BPW)
  - piece = min(remaining, room, MAX_BURST_LENGTH)
  - o_mlength = piece mod 2**LENGTH_WIDTH
  - o_mcmd_final = (piece == remaining)
- o_mcmd_valid = ISSUE && !(with_data && fifo_full).
- On o_mcmd_valid && i_scmd_accept:
  - addr += piece*BPW; remaining -= piece.
  - If with_data, push piece into the FIFO.
  - If final, go to IDLE. No bubble is required: the next command is accepted in the following IDLE cycle.
- Data path, combinational passthrough gated by FIFO non-empty:
  - o_mdata_valid = i_mdata_valid && !fifo_empty
  - o_sdata_accept = i_sdata_accept && !fifo_empty
  - o_mdata_last = (beat_cnt == fifo_head - 1)
- On a data handshake: if last, pop the FIFO and clear beat_cnt; otherwise beat_cnt++.
- Simultaneous push and pop in one cycle is legal, including when the FIFO is full. A push is only blocked by full at cycle start: o_mcmd_valid is held 0 while the FIFO is full.
- Data beats may arrive before their piece command. They stall until the FIFO is non-empty and are never dropped.
- Read commands never touch the FIFO or the data path.
- Reset mid-operation clears all state immediately. A partially issued command is discarded.

Test Plan:
- Write, addr 0x0FF0, len 4, BPW 16 -> pieces (0x0FF0, len 1, final=0) and (0x1000, len 3, final=1); o_mdata_last on beats 0 and 3.
- Read, addr 0x0, i_mlength=0 (1024 words) -> 4 pieces at 0x0/0x1000/0x2000/0x3000, o_mlength=256 each, final only on the 4th; no data activity.
- Write, addr 0x2000, len 16 -> single piece (0x2000, 16, final=1); last on beat 15; upstream accepted one cycle, piece valid the next.
- Six consecutive 1-word-piece write commands with data held off -> o_mcmd_valid drops after 4 FIFO pushes; after data is released, issue resumes and all 6 lasts are asserted correctly.
- Random i_scmd_accept/i_sdata_accept backpressure on mixed reads/writes -> outputs stable while valid and not accepted; beat counts match piece lengths.
- Assert reset during the second piece of a 4-piece read -> all valids 0; next command is accepted and split from scratch.

Source files
------------

// File: rtl/pzcorebus_axi_boundary_splitter.sv
//------------------------------------------------------------------------------
// Module   : pzcorebus_axi_boundary_splitter
// Function : Splits corebus commands into pieces that never cross a 4 KB
//            boundary nor exceed MAX_BURST_LENGTH words; regenerates the
//            per-piece write-data last and flags the final piece.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pzcorebus_axi_boundary_splitter #(
  parameter int ADDRESS_WIDTH    = 64,
  parameter int DATA_WIDTH       = 128,
  parameter int ID_WIDTH         = 8,
  parameter int LENGTH_WIDTH     = 10,
  parameter int MAX_BURST_LENGTH = 256,
  parameter int PIECE_FIFO_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic                      i_mcmd_with_data,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
  input  logic [LENGTH_WIDTH-1:0]   i_mlength,
  input  logic                      i_mdata_valid,
  output logic                      o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
  input  logic                      i_mdata_last,
  output logic                      o_mcmd_valid,
  input  logic                      i_scmd_accept,
  output logic                      o_mcmd_with_data,
  output logic [ID_WIDTH-1:0]       o_mid,
  output logic [ADDRESS_WIDTH-1:0]  o_maddr,
  output logic [LENGTH_WIDTH-1:0]   o_mlength,
  output logic                      o_mcmd_final,
  output logic                      o_mdata_valid,
  input  logic                      i_sdata_accept,
  output logic [DATA_WIDTH-1:0]     o_mdata,
  output logic [DATA_WIDTH/8-1:0]   o_mdata_byteen,
  output logic                      o_mdata_last
);

  localparam int BPW         = DATA_WIDTH / 8;
  localparam int BPW_SHIFT   = $clog2(BPW);
  // Remaining/piece lengths need one extra bit to hold 2**LENGTH_WIDTH.
  localparam int REM_WIDTH   = LENGTH_WIDTH + 1;
  // Piece arithmetic must also hold a full 4 KB worth of words (up to 4096).
  localparam int PIECE_WIDTH = (REM_WIDTH > 13) ? REM_WIDTH : 13;
  localparam int PTR_WIDTH   = (PIECE_FIFO_DEPTH > 1) ? $clog2(PIECE_FIFO_DEPTH) : 1;
  localparam int CNT_WIDTH   = $clog2(PIECE_FIFO_DEPTH + 1);

  localparam logic [12:0] BOUNDARY_BYTES = 13'd4096;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]               state;
  logic [0:0]               state_next;

  logic                     with_data;
  logic [ID_WIDTH-1:0]      id;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [REM_WIDTH-1:0]     remaining;

  logic [12:0]              room_bytes;
  logic [PIECE_WIDTH-1:0]   room;
  logic [PIECE_WIDTH-1:0]   piece;
  logic                     piece_final;
  logic [REM_WIDTH-1:0]     piece_len;

  logic                     capture;
  logic                     cmd_fire;
  logic                     data_fire;

  logic [REM_WIDTH-1:0]     fifo_mem [PIECE_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr;
  logic [PTR_WIDTH-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0]     fifo_count;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [REM_WIDTH-1:0]     fifo_head;
  logic [REM_WIDTH-1:0]     beat_cnt;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(PIECE_FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign capture   = (state == IDLE) && i_mcmd_valid;
  assign cmd_fire  = o_mcmd_valid && i_scmd_accept;
  assign data_fire = o_mdata_valid && i_sdata_accept;

  // Command FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Command FSM next-state: leave ISSUE once the final piece is handed off.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_mcmd_valid) state_next = ISSUE;
      ISSUE:   if (cmd_fire && piece_final) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command FSM outputs: accept upstream in IDLE, offer pieces in ISSUE while
  // a write still has room in the piece FIFO.
  always_comb begin
    o_scmd_accept = 1'b0;
    o_mcmd_valid  = 1'b0;
    case (state)
      IDLE:    o_scmd_accept = 1'b1;
      ISSUE:   o_mcmd_valid  = !(with_data && fifo_full);
      default: o_mcmd_valid  = 1'b0;
    endcase
  end

  // Captured command and running address/remaining, advanced per issued piece.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      with_data <= 1'b0;
      id        <= '0;
      addr      <= '0;
      remaining <= '0;
    end else if (capture) begin
      with_data <= i_mcmd_with_data;
      id        <= i_mid;
      addr      <= i_maddr;
      remaining <= {(i_mlength == '0), i_mlength};
    end else if (cmd_fire) begin
      addr      <= addr + (ADDRESS_WIDTH'(piece) << BPW_SHIFT);
      remaining <= remaining - piece_len;
    end
  end

  // Piece size: smallest of what is left, what fits before the 4 KB line,
  // and the burst cap.
  always_comb begin
    room_bytes = BOUNDARY_BYTES - {1'b0, addr[11:0]};
    room       = PIECE_WIDTH'(room_bytes >> BPW_SHIFT);
    piece      = PIECE_WIDTH'(remaining);
    if (room < piece) piece = room;
    if (PIECE_WIDTH'(MAX_BURST_LENGTH) < piece) piece = PIECE_WIDTH'(MAX_BURST_LENGTH);
    piece_final = (piece == PIECE_WIDTH'(remaining));
    piece_len   = piece[REM_WIDTH-1:0];
  end

  assign o_mcmd_with_data = with_data;
  assign o_mid            = id;
  assign o_maddr          = addr;
  assign o_mlength        = piece[LENGTH_WIDTH-1:0];
  assign o_mcmd_final     = piece_final;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_WIDTH'(PIECE_FIFO_DEPTH));
  assign fifo_push  = cmd_fire && with_data;
  assign fifo_pop   = data_fire && o_mdata_last;
  assign fifo_head  = fifo_mem[rd_ptr];

  // Piece-length storage; contents are only meaningful while counted valid.
  always_ff @(posedge i_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= piece_len;
  end

  // Piece FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Data beats only flow once their piece length is known.
  assign o_mdata        = i_mdata;
  assign o_mdata_byteen = i_mdata_byteen;
  assign o_mdata_valid  = i_mdata_valid && !fifo_empty;
  assign o_sdata_accept = i_sdata_accept && !fifo_empty;
  assign o_mdata_last   = !fifo_empty && (beat_cnt == fifo_head - REM_WIDTH'(1));

  // Beat counter within the current write piece.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      beat_cnt <= '0;
    else if (data_fire) beat_cnt <= o_mdata_last ? '0 : beat_cnt + REM_WIDTH'(1);
  end

`ifndef SYNTHESIS
  // The end of an original command is always also the end of a piece.
  upstream_last_is_piece_end: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (data_fire && i_mdata_last) |-> o_mdata_last
  );
`endif

endmodule

`default_nettype wire
